// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Request/grant/response bundle for the two masters of the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [AWIDTH-1:0] m0_addr;
  logic [DWIDTH-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DWIDTH-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [AWIDTH-1:0] m1_addr;
  logic [DWIDTH-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DWIDTH-1:0] m1_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares a 1R1W registered-read memory between fetch (M0) and LSU
//            (M1); read and write ports arbitrated independently.
//            Define ARB_ROUND_ROBIN_EN for round-robin, else fixed M0 priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  mem_port_arbiter_if.slave      bus,
  output logic                   mem_re,
  output logic [AWIDTH-1:0]      mem_raddr,
  input  wire logic [DWIDTH-1:0] mem_rdata,
  output logic                   mem_we,
  output logic [AWIDTH-1:0]      mem_waddr,
  output logic [DWIDTH-1:0]      mem_wdata
);

  logic [1:0] rd_req;
  logic [1:0] wr_req;
  logic [1:0] rd_gnt;
  logic [1:0] wr_gnt;

  // Response tag: one outstanding read per cycle, owner identifies the master.
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_owner_q, rsp_owner_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Last winner per class; 1 = M1, so M0 wins the first contest after reset.
  logic rd_last_q, rd_last_d;
  logic wr_last_q, wr_last_d;
`endif

  always_comb begin
    rd_req = {bus.m1_req & ~bus.m1_we, bus.m0_req & ~bus.m0_we};
    wr_req = {bus.m1_req &  bus.m1_we, bus.m0_req &  bus.m0_we};

`ifdef ARB_ROUND_ROBIN_EN
    rd_gnt[0] = rd_req[0] & (~rd_req[1] |  rd_last_q);
    rd_gnt[1] = rd_req[1] & (~rd_req[0] | ~rd_last_q);
    wr_gnt[0] = wr_req[0] & (~wr_req[1] |  wr_last_q);
    wr_gnt[1] = wr_req[1] & (~wr_req[0] | ~wr_last_q);
`else
    rd_gnt[0] = rd_req[0];
    rd_gnt[1] = rd_req[1] & ~rd_req[0];
    wr_gnt[0] = wr_req[0];
    wr_gnt[1] = wr_req[1] & ~wr_req[0];
`endif

    if (rst) begin
      rd_gnt = 2'b00;
      wr_gnt = 2'b00;
    end

    rsp_valid_d = |rd_gnt;
    rsp_owner_d = rd_gnt[1];

`ifdef ARB_ROUND_ROBIN_EN
    rd_last_d = rd_last_q;
    wr_last_d = wr_last_q;
    if (|rd_gnt) rd_last_d = rd_gnt[1];
    if (|wr_gnt) wr_last_d = wr_gnt[1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rd_last_q   <= 1'b1;
      wr_last_q   <= 1'b1;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      rd_last_q   <= rd_last_d;
      wr_last_q   <= wr_last_d;
`endif
    end
  end

  // A master issues either a read or a write, so OR-ing the classes is safe.
  assign bus.m0_gnt    = rd_gnt[0] | wr_gnt[0];
  assign bus.m1_gnt    = rd_gnt[1] | wr_gnt[1];
  assign bus.m0_rvalid = rsp_valid_q & ~rsp_owner_q;
  assign bus.m1_rvalid = rsp_valid_q &  rsp_owner_q;
  assign bus.m0_rdata  = mem_rdata;
  assign bus.m1_rdata  = mem_rdata;

  assign mem_re    = |rd_gnt;
  assign mem_raddr = rd_gnt[1] ? bus.m1_addr  : bus.m0_addr;
  assign mem_we    = |wr_gnt;
  assign mem_waddr = wr_gnt[1] ? bus.m1_addr  : bus.m0_addr;
  assign mem_wdata = wr_gnt[1] ? bus.m1_wdata : bus.m0_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed and randomized checks of mem_port_arbiter with a
//            behavioural 1R1W memory and an arbitration reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AWIDTH(16), .DWIDTH(16)) bus ();

  logic        mem_re, mem_we;
  logic [15:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.AWIDTH(16), .DWIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  // Registered-read memory; NBA ordering gives read-before-write on collisions.
  logic [15:0] mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_raddr];
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  int checks = 0;
  int failures = 0;

  task automatic drv(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                     input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    step();
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv(1, 0, 16'h0003, 0, 1, 1, 16'h0004, 16'hFFFF);
    step();
    @(negedge clk);
    checks++; if (bus.m0_gnt !== 1'b0) begin failures++; $display("FAIL reset_m0_gnt got=%b exp=0", bus.m0_gnt); end
    checks++; if (bus.m1_gnt !== 1'b0) begin failures++; $display("FAIL reset_m1_gnt got=%b exp=0", bus.m1_gnt); end
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL reset_mem_re got=%b exp=0", mem_re); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    step();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.m0_rvalid !== 1'b0) begin failures++; $display("FAIL reset_m0_rvalid got=%b exp=0", bus.m0_rvalid); end
    checks++; if (bus.m1_rvalid !== 1'b0) begin failures++; $display("FAIL reset_m1_rvalid got=%b exp=0", bus.m1_rvalid); end
    step();
  endtask

  task automatic test_concurrent();
    preload(16'h0010, 16'hBEEF);
    drv(1, 0, 16'h0010, 0, 1, 1, 16'h0020, 16'h1234);
    @(negedge clk);
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b11) begin failures++; $display("FAIL conc_gnt got=%b exp=11", {bus.m0_gnt, bus.m1_gnt}); end
    checks++; if ({mem_re, mem_we} !== 2'b11) begin failures++; $display("FAIL conc_mem_en got=%b exp=11", {mem_re, mem_we}); end
    checks++; if (mem_raddr !== 16'h0010 || mem_waddr !== 16'h0020 || mem_wdata !== 16'h1234) begin
      failures++; $display("FAIL conc_mem_bus got=%h/%h/%h exp=0010/0020/1234", mem_raddr, mem_waddr, mem_wdata); end
    step();
    drv(0, 0, 0, 0, 1, 0, 16'h0020, 0);
    @(negedge clk);
    checks++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'hBEEF) begin
      failures++; $display("FAIL conc_m0_rsp got=%b/%h exp=1/beef", bus.m0_rvalid, bus.m0_rdata); end
    checks++; if (bus.m1_rvalid !== 1'b0) begin failures++; $display("FAIL conc_m1_rvalid got=%b exp=0", bus.m1_rvalid); end
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 16'h1234 || bus.m0_rvalid !== 1'b0) begin
      failures++; $display("FAIL conc_m1_readback got=%b/%h/%b exp=1/1234/0", bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid); end
    step();
  endtask

  task automatic test_contention();
    logic exp0, exp_prev0, exp_prev1;
    preload(16'h0001, 16'h1111);
    preload(16'h0002, 16'h2222);
    do_reset();
    exp_prev0 = 1'b0; exp_prev1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drv(1, 0, 16'h0001, 0, 1, 0, 16'h0002, 0);
      else       drv(0, 0, 0, 0, 0, 0, 0, 0);
      exp0 = (c < 4) && (!RR || (c % 2 == 0));
      @(negedge clk);
      if (c < 4) begin
        checks++; if ({bus.m0_gnt, bus.m1_gnt} !== {exp0, ~exp0}) begin
          failures++; $display("FAIL cont_gnt c=%0d got=%b exp=%b", c, {bus.m0_gnt, bus.m1_gnt}, {exp0, ~exp0}); end
      end
      checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== {exp_prev0, exp_prev1}) begin
        failures++; $display("FAIL cont_rvalid c=%0d got=%b exp=%b", c, {bus.m0_rvalid, bus.m1_rvalid}, {exp_prev0, exp_prev1}); end
      if (exp_prev0 || exp_prev1) begin
        checks++; if (mem_rdata !== (exp_prev0 ? 16'h1111 : 16'h2222)) begin
          failures++; $display("FAIL cont_rdata c=%0d got=%h exp=%h", c, mem_rdata, exp_prev0 ? 16'h1111 : 16'h2222); end
      end
      exp_prev0 = exp0;
      exp_prev1 = (c < 4) && !exp0;
      step();
    end
  endtask

  task automatic test_rbw();
    preload(16'h0005, 16'h5555);
    drv(1, 0, 16'h0005, 0, 1, 1, 16'h0005, 16'hAAAA);
    @(negedge clk);
    checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b11) begin failures++; $display("FAIL rbw_gnt got=%b exp=11", {bus.m0_gnt, bus.m1_gnt}); end
    step();
    drv(1, 0, 16'h0005, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'h5555) begin
      failures++; $display("FAIL rbw_old got=%b/%h exp=1/5555", bus.m0_rvalid, bus.m0_rdata); end
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'hAAAA) begin
      failures++; $display("FAIL rbw_new got=%b/%h exp=1/aaaa", bus.m0_rvalid, bus.m0_rdata); end
    step();
  endtask

  task automatic test_reset_drop();
    drv(0, 0, 0, 0, 1, 0, 16'h0001, 0);
    @(negedge clk);
    checks++; if (bus.m1_gnt !== 1'b1) begin failures++; $display("FAIL drop_gnt got=%b exp=1", bus.m1_gnt); end
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.m1_gnt !== 1'b0 || mem_re !== 1'b0) begin
      failures++; $display("FAIL drop_gnt_in_rst got=%b/%b exp=0/0", bus.m1_gnt, mem_re); end
    step();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) begin
        failures++; $display("FAIL drop_rvalid c=%0d got=%b exp=00", c, {bus.m0_rvalid, bus.m1_rvalid}); end
      step();
    end
  endtask

  task automatic test_random();
    logic [15:0] ref_mem [0:15];
    logic        r0, w0, r1, w1;
    logic [15:0] a0, d0, a1, d1;
    logic        rd0, rd1, wr0, wr1, g0, g1, rd_win1, wr_win1;
    logic        rd_last, wr_last, ev0, ev1;
    logic [15:0] edata;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'($urandom);
      preload(16'(i), ref_mem[i]);
    end
    do_reset();
    rd_last = 1'b1; wr_last = 1'b1; ev0 = 1'b0; ev1 = 1'b0; edata = '0;
    r0 = 0; w0 = 0; a0 = 0; d0 = 0; r1 = 0; w1 = 0; a1 = 0; d1 = 0;
    for (int c = 0; c < 300; c++) begin
      if (!r0) begin r0 = ($urandom_range(0, 3) != 0); w0 = 1'($urandom); a0 = 16'($urandom_range(0, 15)); d0 = 16'($urandom); end
      if (!r1) begin r1 = ($urandom_range(0, 3) != 0); w1 = 1'($urandom); a1 = 16'($urandom_range(0, 15)); d1 = 16'($urandom); end
      drv(r0, w0, a0, d0, r1, w1, a1, d1);
      rd0 = r0 && !w0; rd1 = r1 && !w1; wr0 = r0 && w0; wr1 = r1 && w1;
      // Contested class: M0 under fixed priority, else whoever did not win last.
      rd_win1 = (rd0 && rd1) ? (RR && !rd_last) : rd1;
      wr_win1 = (wr0 && wr1) ? (RR && !wr_last) : wr1;
      g0 = (rd0 && !rd_win1) || (wr0 && !wr_win1);
      g1 = rd_win1 || wr_win1;
      @(negedge clk);
      checks++; if ({bus.m0_gnt, bus.m1_gnt} !== {g0, g1}) begin
        failures++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, {bus.m0_gnt, bus.m1_gnt}, {g0, g1}); end
      checks++; if ({mem_re, mem_we} !== {rd0 || rd1, wr0 || wr1}) begin
        failures++; $display("FAIL rand_mem_en c=%0d got=%b exp=%b", c, {mem_re, mem_we}, {rd0 || rd1, wr0 || wr1}); end
      if (rd0 || rd1) begin
        checks++; if (mem_raddr !== (rd_win1 ? a1 : a0)) begin
          failures++; $display("FAIL rand_raddr c=%0d got=%h exp=%h", c, mem_raddr, rd_win1 ? a1 : a0); end
      end
      if (wr0 || wr1) begin
        checks++; if (mem_waddr !== (wr_win1 ? a1 : a0) || mem_wdata !== (wr_win1 ? d1 : d0)) begin
          failures++; $display("FAIL rand_wr c=%0d got=%h/%h exp=%h/%h", c, mem_waddr, mem_wdata, wr_win1 ? a1 : a0, wr_win1 ? d1 : d0); end
      end
      checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== {ev0, ev1}) begin
        failures++; $display("FAIL rand_rvalid c=%0d got=%b exp=%b", c, {bus.m0_rvalid, bus.m1_rvalid}, {ev0, ev1}); end
      if (ev0 || ev1) begin
        checks++; if ((ev0 ? bus.m0_rdata : bus.m1_rdata) !== edata) begin
          failures++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, ev0 ? bus.m0_rdata : bus.m1_rdata, edata); end
      end
      ev0 = rd0 && !rd_win1;
      ev1 = rd_win1;
      if (rd0 || rd1) edata = ref_mem[4'(rd_win1 ? a1 : a0)];
      if (wr0 || wr1) ref_mem[4'(wr_win1 ? a1 : a0)] = wr_win1 ? d1 : d0;
      if (rd0 || rd1) rd_last = rd_win1;
      if (wr0 || wr1) wr_last = wr_win1;
      if (g0) r0 = 1'b0;
      if (g1) r1 = 1'b0;
      step();
    end
  endtask

  initial begin
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_concurrent();
    test_contention();
    test_rbw();
    test_reset_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
